// File: rtl/nios_system_pio_in_edge.sv
// rtl/nios_system_pio_in_edge.sv - Avalon-MM input PIO with edge capture and irq; optional PIO_IN_DEBOUNCE_EN
module nios_system_pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_ok;

    // Upper writedata bits are don't-care when WIDTH < 32.
    assign unused_ok = &{1'b0, writedata, 16'(DEBOUNCE_CYCLES)};

    assign wr_en   = chipselect & ~write_n;
    assign sync_in = sync_q[SYNC_STAGES-1];

    // Input synchroniser chain for the asynchronous board inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    logic [15:0] db_cnt [WIDTH];

    // Per-bit stability filter: filt only follows sync_in after it has differed long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int b = 0; b < WIDTH; b++) db_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_in[b] != filt[b]) begin
                    if (db_cnt[b] == DB_LAST) begin
                        filt[b]   <= sync_in[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 16'd1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync_in;
`endif

    // One-cycle delayed copy of the filtered input for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= '0;
        else          prev <= filt;
    end

    // Select the edge polarity this instance reports.
    always_comb begin
        edge_hit = filt & ~prev;
        case (EDGE_TYPE)
            1:       edge_hit = ~filt & prev;
            2:       edge_hit = filt ^ prev;
            default: edge_hit = filt & ~prev;
        endcase
    end

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      irqmask <= '0;
        else if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end

    // Sticky edge capture; a new edge beats a same-cycle clear so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgecapture <= '0;
        else          edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |(edgecapture & irqmask);
    end

    // Read mux; unused upper bits stay zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = filt;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// tb/tb_nios_system_pio_in_edge.sv - directed scoreboard bench for nios_system_pio_in_edge
module tb_nios_system_pio_in_edge;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in8;
    logic [31:0] rd8;
    logic        irq8;
    logic [31:0] in32;
    logic [31:0] rd32;
    logic        irq32;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        bit          wide;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    nios_system_pio_in_edge #(
        .WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd8),
        .in_port(in8), .irq(irq8)
    );

    nios_system_pio_in_edge #(
        .WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)
    ) u_dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd32),
        .in_port(in32), .irq(irq32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input bit wide, input logic [31:0] exp, input string tag);
        sb_entry_t e;
        e.exp  = exp;
        e.wide = wide;
        e.tag  = tag;
        sb_q.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        e = sb_q.pop_front();
        chk(e.tag, e.wide ? rd32 : rd8, e.exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in8        = 8'hA5;
        in32       = '0;
        cyc(2);
        chk("reset_readdata", rd8, 32'h0);
        chk("reset_irq", {31'b0, irq8}, 32'h0);
        reset_n = 1'b1;
        cyc(10 + DB);

        // Register map after reset with A5 held
        rd(2'd0, 1'b0, 32'h000000A5, "data_a5");
        rd(2'd1, 1'b0, 32'h0, "reserved_zero");
        rd(2'd2, 1'b0, 32'h0, "irqmask_reset");
        rd(2'd3, 1'b0, 32'h000000A5, "ec_reset_release_edges");
        rd(2'd3, 1'b1, 32'h0, "ec32_reset");
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3, 1'b0, 32'h0, "ec_cleared");
        in8 = 8'h00;
        cyc(5 + DB);
        rd(2'd3, 1'b0, 32'h0, "falling_ignored");

        // Rising edge latency and irq timing
        wr(2'd2, 32'h01);
        rd(2'd2, 1'b0, 32'h01, "irqmask_rw");
        in8 = 8'h01;
        cyc(2 + DB);
        rd(2'd3, 1'b0, 32'h0, "ec_before_latency");
        chk("irq_before", {31'b0, irq8}, 32'h0);
        rd(2'd3, 1'b0, 32'h01, "ec_at_latency");
        chk("irq_after", {31'b0, irq8}, 32'h1);
        in8 = 8'h00;
        cyc(5 + DB);
        rd(2'd3, 1'b0, 32'h01, "fall_sets_nothing");
        wr(2'd3, 32'h01);
        cyc(1);
        chk("irq_cleared", {31'b0, irq8}, 32'h0);

        // Partial clear with mask interplay
        wr(2'd2, 32'h02);
        in8 = 8'h03;
        cyc(5 + DB);
        rd(2'd3, 1'b0, 32'h03, "ec_two_bits");
        wr(2'd3, 32'h01);
        rd(2'd3, 1'b0, 32'h02, "ec_partial_clear");
        chk("irq_mask02", {31'b0, irq8}, 32'h1);
        wr(2'd2, 32'h01);
        chk("irq_mask_lag", {31'b0, irq8}, 32'h1);
        cyc(1);
        chk("irq_mask01", {31'b0, irq8}, 32'h0);

        // Set beats simultaneous clear
        in8 = 8'h02;
        cyc(5 + DB);
        rd(2'd3, 1'b0, 32'h02, "ec_before_race");
        in8 = 8'h03;
        cyc(2 + DB);
        wr(2'd3, 32'h01);
        rd(2'd3, 1'b0, 32'h03, "set_wins_clear");
        wr(2'd3, 32'h03);
        rd(2'd3, 1'b0, 32'h0, "ec_clear_all");

        // Wide instance, any-edge on bit 31
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3, 1'b1, 32'h0, "ec32_clear");
        wr(2'd2, 32'h80000000);
        in32[31] = 1'b1;
        cyc(5 + DB);
        rd(2'd3, 1'b1, 32'h80000000, "ec32_rise");
        rd(2'd0, 1'b1, 32'h80000000, "data32_high");
        chk("irq32_set", {31'b0, irq32}, 32'h1);
        wr(2'd3, 32'h80000000);
        rd(2'd3, 1'b1, 32'h0, "ec32_cleared");
        in32[31] = 1'b0;
        cyc(5 + DB);
        rd(2'd3, 1'b1, 32'h80000000, "ec32_fall");
        rd(2'd0, 1'b1, 32'h0, "data32_low");
        rd(2'd3, 1'b0, 32'h0, "ec8_untouched");
        chk("irq8_masked", {31'b0, irq8}, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
        // Debounce: short glitch filtered, long pulse passes with 16-cycle lag
        in8 = 8'h07;
        cyc(10);
        in8 = 8'h03;
        cyc(40);
        rd(2'd3, 1'b0, 32'h0, "db_glitch_filtered");
        in8 = 8'h07;
        cyc(17);
        rd(2'd0, 1'b0, 32'h03, "db_filt_not_yet");
        rd(2'd0, 1'b0, 32'h07, "db_filt_changed");
        cyc(1);
        in8 = 8'h03;
        cyc(40);
        rd(2'd3, 1'b0, 32'h04, "db_pulse_captured");
`endif

        // Asynchronous reset mid-operation
        wr(2'd2, 32'hFF);
        rd(2'd2, 1'b0, 32'hFF, "irqmask_ff");
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", rd8, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, 1'b0, 32'h0, "irqmask_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
